accum_frame: RTL and testbench
==============================

// Module: accum_frame
// PURPOSE
//  Downstream stage of the difference unit: consumes its dti_s_if stream and
//  sums CNT consecutive samples, or fewer if the frame ends early on din.eot.
//  Emits one result word per frame on a dti_s_if producer port.
//  Used to integrate error/difference samples, e.g. for loop filters.
// PARAMETERS
//  TDIN        16  din.data width in bits
//  TDOUT       32  dout.data width in bits, and accumulator width; must be >= TDIN
//  DIN_SIGNED  1   1: din.data is two's complement, sign-extended; 0: zero-extended
//  CNT         8   max samples per frame, >= 1; counter width $clog2(CNT+1)
// PORTS
//  clk         in   1      clock; all state updates on the rising edge
//  rst         in   1      synchronous reset, active-high
//  din.data    in   TDIN   input sample
//  din.dvalid  in   1      input sample valid
//  din.eot     in   1      last sample of the frame
//  din.dready  out  1      sample accepted this cycle
//  dout.data   out  TDOUT  frame sum
//  dout.dvalid out  1      result valid
//  dout.eot    out  1      1 if the frame was closed by din.eot, 0 if closed by count
//  dout.dready in   1      downstream accepts the result
// BEHAVIOUR
//  Reset values:
//   - state=ACC, acc=0, cnt=0, eot_q=0
//   - outputs: din.dready=1, dout.dvalid=0, dout.data=0, dout.eot=0
//  FSM states: ACC and OUT.
//   - ACC: din.dready=1, dout.dvalid=0.
//   - OUT: din.dready=0, dout.dvalid=1, dout.data=acc, dout.eot=eot_q.
//  Input accept: din.dvalid & din.dready.
//   - On accept: acc <= acc + ext(din.data); cnt <= cnt+1.
//   - If din.eot=1 or cnt==CNT-1: go to OUT; eot_q <= din.eot.
//  Output handshake: dout.dvalid & dout.dready.
//   - On handshake: acc <= 0, cnt <= 0, eot_q <= 0, go to ACC.
//   - Without dout.dready: hold OUT; data and eot stay stable.
//  Latency: result valid the cycle after the last sample is accepted.
//   - Exactly one bubble cycle per frame; no input is accepted while in OUT.
//  Arithmetic:
//   - ext() is sign- or zero-extension of din.data to TDOUT per DIN_SIGNED.
//   - Addition wraps modulo 2^TDOUT unless ACCUM_FRAME_SAT_EN is defined.
//  Boundaries:
//   - CNT=1: every sample is its own frame; output equals ext(sample).
//   - din.eot on the CNT-th sample: frame closes once, with dout.eot=1.
//   - din.dvalid while in OUT: ignored, not consumed; upstream holds it.
//   - rst mid-frame or in OUT: partial sum discarded; next cycle is the reset state.
//   - A zero-length frame cannot occur; an eot always arrives with a sample.
// CONFIGURATION
//  ACCUM_FRAME_SAT_EN defined:
//   - Sum computed at TDOUT+1 bits, then clamped.
//   - Signed (DIN_SIGNED=1): clamp to [-2^(TDOUT-1), 2^(TDOUT-1)-1].
//   - Unsigned (DIN_SIGNED=0): clamp to 2^TDOUT-1.
//   - A saturated acc stays clamped while further samples push it the same way.
//  Not defined: plain modulo-2^TDOUT wrap; no extra logic.
// TESTING
//  T1 default params; samples 1..8, dout.dready=1 -> one result 36, eot=0,
//     din.dready=0 for exactly 1 cycle.
//  T2 samples 5,-3,7 with eot on the 7 -> result 9, eot=1; next frame starts clean at acc=0.
//  T3 dout.dready=0 for 4 cycles in OUT -> data and eot stable, din.dready=0,
//     no input consumed, no sample lost.
//  T4 TDIN=8, TDOUT=8, DIN_SIGNED=1, samples 100,100:
//     no macro -> -56; ACCUM_FRAME_SAT_EN -> 127.
//  T5 rst asserted after 3 of 8 samples -> next frame of 8 ones gives 8, not 8+partial.
//  T6 CNT=1, DIN_SIGNED=0, TDIN=4, sample 4'hF -> result 15 each frame, back-to-back with bubbles.

Source files
------------

// File: rtl/accum_frame.sv
// accum_frame -- frame accumulator behind the difference unit.
//
// Sums up to CNT consecutive input samples, or fewer when a sample arrives
// with din_eot set, and presents one result word per frame. While the
// result is waiting for dout_dready, no new sample is accepted.
//
// Ports (the din_* / dout_* groups are a flattened dti_s_if consumer/producer):
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   din_data     in   TDIN   input sample
//   din_dvalid   in   1      input sample valid
//   din_eot      in   1      last sample of the frame
//   din_dready   out  1      sample accepted this cycle (high in ACC)
//   dout_data    out  TDOUT  frame sum
//   dout_dvalid  out  1      result valid (high in OUT)
//   dout_eot     out  1      1: frame closed by din_eot, 0: closed by count
//   dout_dready  in   1      downstream accepts the result
//
// Parameters: TDIN, TDOUT (>= TDIN), DIN_SIGNED, CNT (>= 1).
// Optional feature: define ACCUM_FRAME_SAT_EN to clamp the accumulator
// instead of letting it wrap modulo 2^TDOUT.

module accum_frame #(
  parameter int TDIN       = 16,
  parameter int TDOUT      = 32,
  parameter int DIN_SIGNED = 1,
  parameter int CNT        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TDIN-1:0]  din_data,
  input  logic             din_dvalid,
  input  logic             din_eot,
  output logic             din_dready,
  output logic [TDOUT-1:0] dout_data,
  output logic             dout_dvalid,
  output logic             dout_eot,
  input  logic             dout_dready
);

  localparam int CW = $clog2(CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT - 1);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [TDOUT-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eot_q, eot_d;

  logic [TDOUT-1:0] ext_s;
  logic [TDOUT-1:0] sum_s;

  // Extend the incoming sample to accumulator width.
  always_comb begin
    if (DIN_SIGNED != 0) begin
      ext_s = TDOUT'($signed(din_data));
    end else begin
      ext_s = TDOUT'(din_data);
    end
  end

`ifdef ACCUM_FRAME_SAT_EN
  localparam logic [TDOUT-1:0] SMIN = TDOUT'(1) << (TDOUT - 1);
  localparam logic [TDOUT-1:0] SMAX = ~SMIN;

  logic [TDOUT:0] wide_s;

  // One extra bit of headroom exposes overflow; clamp instead of wrapping.
  always_comb begin
    if (DIN_SIGNED != 0) begin
      wide_s = {acc_q[TDOUT-1], acc_q} + {ext_s[TDOUT-1], ext_s};
      // Overflow when the top two bits disagree; the top bit gives the direction.
      if (wide_s[TDOUT] != wide_s[TDOUT-1]) begin
        sum_s = wide_s[TDOUT] ? SMIN : SMAX;
      end else begin
        sum_s = wide_s[TDOUT-1:0];
      end
    end else begin
      wide_s = {1'b0, acc_q} + {1'b0, ext_s};
      if (wide_s[TDOUT]) begin
        sum_s = {TDOUT{1'b1}};
      end else begin
        sum_s = wide_s[TDOUT-1:0];
      end
    end
  end
`else
  // Plain modulo-2^TDOUT accumulation.
  always_comb begin
    sum_s = acc_q + ext_s;
  end
`endif

  // Next-state logic: accumulate in ACC, hold the result in OUT until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    eot_d   = eot_q;
    case (state_q)
      ST_ACC: begin
        // din_dready is high throughout ACC, so dvalid alone means accept.
        if (din_dvalid) begin
          acc_d = sum_s;
          cnt_d = cnt_q + CW'(1);
          if (din_eot || (cnt_q == CNT_LAST)) begin
            state_d = ST_OUT;
            eot_d   = din_eot;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (dout_dready) begin
          state_d = ST_ACC;
          acc_d   = {TDOUT{1'b0}};
          cnt_d   = {CW{1'b0}};
          eot_d   = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACC;
        acc_d   = {TDOUT{1'b0}};
        cnt_d   = {CW{1'b0}};
        eot_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= {TDOUT{1'b0}};
      cnt_q   <= {CW{1'b0}};
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      eot_q   <= eot_d;
    end
  end

  // Outputs come straight from flops; eot_q is only ever set while in OUT.
  assign din_dready  = (state_q == ST_ACC);
  assign dout_dvalid = (state_q == ST_OUT);
  assign dout_data   = acc_q;
  assign dout_eot    = eot_q;

endmodule

// File: tb/tb_accum_frame.sv
// Testbench for accum_frame: randomized frames checked by a scoreboard
// against an arithmetic reference model, plus directed CNT=1 and
// narrow-accumulator overflow cases on extra instances.

module tb_accum_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] din_data;
  logic        din_dvalid, din_eot, din_dready;
  logic [31:0] dout_data;
  logic        dout_dvalid, dout_eot, dout_dready;

  // CNT=1, unsigned 4-bit input
  logic [3:0]  a_din_data;
  logic        a_din_dvalid, a_din_eot, a_din_dready;
  logic [7:0]  a_dout_data;
  logic        a_dout_dvalid, a_dout_eot, a_dout_dready;

  // 8-bit signed input into 8-bit accumulator
  logic [7:0]  b_din_data;
  logic        b_din_dvalid, b_din_eot, b_din_dready;
  logic [7:0]  b_dout_data;
  logic        b_dout_dvalid, b_dout_eot, b_dout_dready;

  accum_frame u_dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_dvalid(din_dvalid), .din_eot(din_eot), .din_dready(din_dready),
    .dout_data(dout_data), .dout_dvalid(dout_dvalid), .dout_eot(dout_eot), .dout_dready(dout_dready)
  );

  accum_frame #(.TDIN(4), .TDOUT(8), .DIN_SIGNED(0), .CNT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .din_data(a_din_data), .din_dvalid(a_din_dvalid), .din_eot(a_din_eot), .din_dready(a_din_dready),
    .dout_data(a_dout_data), .dout_dvalid(a_dout_dvalid), .dout_eot(a_dout_eot), .dout_dready(a_dout_dready)
  );

  accum_frame #(.TDIN(8), .TDOUT(8), .DIN_SIGNED(1), .CNT(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .din_data(b_din_data), .din_dvalid(b_din_dvalid), .din_eot(b_din_eot), .din_dready(b_din_dready),
    .dout_data(b_dout_data), .dout_dvalid(b_dout_dvalid), .dout_eot(b_dout_eot), .dout_dready(b_dout_dready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  logic [31:0] exp_data_q[$];
  logic        exp_eot_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator
  initial begin
    dout_dready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: dout_dready = 1'b1;
        1: dout_dready = ($urandom_range(0, 3) != 0);
        default: dout_dready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops on every output handshake, plus protocol checks
  initial begin
    int pos;
    logic want_valid, want_ready, hold, held_e;
    logic [31:0] held_d;
    pos = 0; want_valid = 1'b0; want_ready = 1'b0; hold = 1'b0;
    held_d = 32'd0; held_e = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = 0; want_valid = 1'b0; want_ready = 1'b0; hold = 1'b0;
      end else begin
        if (want_valid) chk("latency_valid", dout_dvalid, 1);
        if (want_ready) chk("bubble_ready", din_dready, 1);
        if (hold) begin
          chk("stall_data", dout_data, held_d);
          chk("stall_eot", dout_eot, held_e);
        end
        want_valid = 1'b0; want_ready = 1'b0; hold = 1'b0;
        if (dout_dvalid) chk("no_accept_in_out", din_dready, 0);
        if (din_dvalid && din_dready) begin
          pos++;
          if (din_eot || pos == 8) begin
            want_valid = 1'b1;
            pos = 0;
          end
        end
        if (dout_dvalid && dout_dready) begin
          if (exp_data_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: got %0h with empty scoreboard", dout_data);
          end else begin
            chk("frame_sum", dout_data, exp_data_q.pop_front());
            chk("frame_eot", dout_eot, exp_eot_q.pop_front());
          end
          want_ready = 1'b1;
        end else if (dout_dvalid) begin
          hold = 1'b1; held_d = dout_data; held_e = dout_eot;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic e);
    int guard;
    logic done;
    guard = 0; done = 1'b0;
    din_data = d; din_eot = e; din_dvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (din_dready) done = 1'b1;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: sample %0h not accepted", d);
        done = 1'b1;
      end
    end
    din_dvalid = 1'b0; din_eot = 1'b0;
  endtask

  // Reference model: frame sum is the plain signed sum of the samples mod 2^32.
  task automatic run_frame(input logic [15:0] s[$], input logic eot_last, input logic gaps);
    longint sum;
    sum = 0;
    foreach (s[i]) sum += longint'($signed(s[i]));
    exp_data_q.push_back(sum[31:0]);
    exp_eot_q.push_back(eot_last);
    foreach (s[i]) begin
      send(s[i], (i == s.size() - 1) ? eot_last : 1'b0);
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_data_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (exp_data_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_data_q.size());
    end
  endtask

  initial begin
    logic [15:0] s[$];
    logic [7:0]  b_exp;
    int          len;
    logic        el;

    rst = 1'b1;
    din_data = 16'd0; din_dvalid = 1'b0; din_eot = 1'b0;
    a_din_data = 4'd0; a_din_dvalid = 1'b0; a_din_eot = 1'b0; a_dout_dready = 1'b1;
    b_din_data = 8'd0; b_din_dvalid = 1'b0; b_din_eot = 1'b0; b_dout_dready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_din_dready", din_dready, 1);
    chk("reset_dout_dvalid", dout_dvalid, 0);
    chk("reset_dout_data", dout_data, 0);
    chk("reset_dout_eot", dout_eot, 0);
    @(posedge clk);
    #1;

    // T1: 1..8 -> 36, closed by count
    s = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    run_frame(s, 1'b0, 1'b0);
    drain();
    // T2: 5,-3,7 with eot -> 9, eot=1; then a fresh frame starts at zero
    s = '{16'd5, 16'hFFFD, 16'd7};
    run_frame(s, 1'b1, 1'b0);
    s = '{16'd10};
    run_frame(s, 1'b1, 1'b0);
    drain();

    // T3: result stalled for several cycles while upstream offers the next sample
    fork
      begin
        rdy_mode = 2;
        repeat (6) @(posedge clk);
        rdy_mode = 0;
      end
    join_none
    s = '{16'd3, 16'd4};
    run_frame(s, 1'b1, 1'b0);
    s = '{16'd100, 16'd200};
    run_frame(s, 1'b1, 1'b0);
    drain();

    // eot on the 8th sample closes the frame once with eot=1
    s = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    run_frame(s, 1'b1, 1'b0);
    drain();

    // T5: partial frame discarded by reset
    send(16'd50, 1'b0);
    send(16'd60, 1'b0);
    send(16'd70, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    s = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    run_frame(s, 1'b0, 1'b0);
    drain();

    // Randomized frames with random backpressure and input gaps
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 8);
      el  = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      s.delete();
      for (int k = 0; k < len; k++) s.push_back(16'($urandom_range(0, 65535)));
      run_frame(s, el, 1'b1);
    end
    drain();
    rdy_mode = 0;

    // T6: CNT=1, each 4'hF sample is its own frame, one bubble each
    @(posedge clk);
    #1;
    a_din_data = 4'hF; a_din_dvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cnt1_dvalid", a_dout_dvalid, (i % 2 == 1) ? 1 : 0);
      chk("cnt1_dready", a_din_dready, (i % 2 == 1) ? 0 : 1);
      if (i % 2 == 1) begin
        chk("cnt1_data", a_dout_data, 15);
        chk("cnt1_eot", a_dout_eot, 0);
      end
    end
    @(posedge clk);
    #1 a_din_dvalid = 1'b0;

    // T4: 100 + 100 in an 8-bit signed accumulator
`ifdef ACCUM_FRAME_SAT_EN
    b_exp = 8'h7F;
`else
    b_exp = 8'hC8;
`endif
    b_din_data = 8'd100; b_din_dvalid = 1'b1; b_din_eot = 1'b0;
    @(posedge clk);
    #1 b_din_eot = 1'b1;
    @(posedge clk);
    #1 b_din_dvalid = 1'b0; b_din_eot = 1'b0;
    @(negedge clk);
    chk("ovf_dvalid", b_dout_dvalid, 1);
    chk("ovf_data", b_dout_data, b_exp);
    chk("ovf_eot", b_dout_eot, 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
